fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the CPU datapath/control. Owns the program counter, drives the instruction-port address of the RAM, captures the returned instruction byte into an instruction register and presents it to decode/control with a valid/ready handshake. Branch redirects from execute are applied on the acceptance cycle; an optional halt detector stops fetching.

---
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the instruction RAM and hands the
// registered instruction to decode. Optional halt detection with `FETCH_HALT_EN.
module fetch_unit #(
   parameter int                    PC_WIDTH     = 8,
   parameter int                    INSN_WIDTH   = 8,
   parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = 8'h00,
   parameter logic [3:0]            HALT_OPCODE  = 4'hF
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [PC_WIDTH-1:0]   pc,
   input  logic [INSN_WIDTH-1:0] ram_insn,
   input  logic                  stall,
   output logic [INSN_WIDTH-1:0] insn,
   output logic [PC_WIDTH-1:0]   insn_pc,
   output logic                  insn_valid,
   input  logic                  insn_ready,
   input  logic                  branch_taken,
   input  logic [PC_WIDTH-1:0]   branch_target,
   output logic                  halted
);

   localparam logic [1:0] S_ISSUE   = 2'd0;
   localparam logic [1:0] S_CAPTURE = 2'd1;
   localparam logic [1:0] S_VALID   = 2'd2;
`ifdef FETCH_HALT_EN
   localparam logic [1:0] S_HALT    = 2'd3;
`endif

   logic [1:0]            r_state;
   logic [PC_WIDTH-1:0]   r_pc;
   logic [INSN_WIDTH-1:0] r_insn;
   logic [PC_WIDTH-1:0]   r_insnPc;
   logic                  r_insnValid;
   logic                  w_accept;

   assign w_accept = r_insnValid && insn_ready;

`ifdef FETCH_HALT_EN
   logic r_halted;
   logic r_haltPending;

   // Halt is decided at capture time so the accept cycle needs no decode of r_insn.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= S_ISSUE;
         r_pc          <= RESET_VECTOR;
         r_insn        <= '0;
         r_insnPc      <= '0;
         r_insnValid   <= 1'b0;
         r_halted      <= 1'b0;
         r_haltPending <= 1'b0;
      end else begin
         case (r_state)
            S_ISSUE: begin
               if (!stall) r_state <= S_CAPTURE;
            end
            S_CAPTURE: begin
               r_insn        <= ram_insn;
               r_insnPc      <= r_pc;
               r_insnValid   <= 1'b1;
               r_pc          <= r_pc + 1'b1;
               r_haltPending <= (ram_insn[INSN_WIDTH-1 -: 4] == HALT_OPCODE);
               r_state       <= S_VALID;
            end
            S_VALID: begin
               if (w_accept) begin
                  r_insnValid <= 1'b0;
                  if (r_haltPending) begin
                     r_halted      <= 1'b1;
                     r_haltPending <= 1'b0;
                     r_state       <= S_HALT;
                  end else begin
                     if (branch_taken) r_pc <= branch_target;
                     r_state <= S_ISSUE;
                  end
               end
            end
            S_HALT: begin
               r_state <= S_HALT;
            end
            default: r_state <= S_ISSUE;
         endcase
      end
   end

   assign halted = r_halted;
`else
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_ISSUE;
         r_pc        <= RESET_VECTOR;
         r_insn      <= '0;
         r_insnPc    <= '0;
         r_insnValid <= 1'b0;
      end else begin
         case (r_state)
            S_ISSUE: begin
               if (!stall) r_state <= S_CAPTURE;
            end
            S_CAPTURE: begin
               r_insn      <= ram_insn;
               r_insnPc    <= r_pc;
               r_insnValid <= 1'b1;
               r_pc        <= r_pc + 1'b1;
               r_state     <= S_VALID;
            end
            S_VALID: begin
               if (w_accept) begin
                  r_insnValid <= 1'b0;
                  if (branch_taken) r_pc <= branch_target;
                  r_state <= S_ISSUE;
               end
            end
            default: r_state <= S_ISSUE;
         endcase
      end
   end

   assign halted = 1'b0;
`endif

   assign pc         = r_pc;
   assign insn       = r_insn;
   assign insn_pc    = r_insnPc;
   assign insn_valid = r_insnValid;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected {insn, insn_pc},
// a monitor pops and compares on every accepted instruction.
module tb_fetch_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] pc;
   logic [7:0] ram_insn = 8'h00;
   logic       stall = 1'b0;
   logic [7:0] insn;
   logic [7:0] insn_pc;
   logic       insn_valid;
   logic       insn_ready = 1'b0;
   logic       branch_taken = 1'b0;
   logic [7:0] branch_target = 8'h00;
   logic       halted;

   logic [7:0]  mem [256];
   logic [15:0] expQ [$];
   int          nCompared = 0;
   int          nMismatched = 0;
   int          cycleCount = 0;

   fetch_unit dut (
      .clk(clk), .rst(rst), .pc(pc), .ram_insn(ram_insn), .stall(stall),
      .insn(insn), .insn_pc(insn_pc), .insn_valid(insn_valid),
      .insn_ready(insn_ready), .branch_taken(branch_taken),
      .branch_target(branch_target), .halted(halted)
   );

   always #5 clk = ~clk;

   // Synchronous-read instruction RAM: data for pc appears one cycle later.
   always @(posedge clk) begin
      ram_insn <= mem[pc];
      cycleCount <= cycleCount + 1;
   end

   task automatic checkOutput(input string nm, input logic [15:0] act, input logic [15:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic pushExp(input logic [7:0] i, input logic [7:0] a);
      expQ.push_back({i, a});
   endtask

   task automatic waitValid(input string nm);
      int n;
      n = 0;
      @(negedge clk);
      while (!insn_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!insn_valid) begin
         nCompared++;
         nMismatched++;
         $display("[TB] FAIL %s: timeout waiting insn_valid got 0 expected 1", nm);
      end
   endtask

   // Called at a negedge with insn_valid high; performs one accept handshake.
   task automatic applyStimulus(input logic br, input logic [7:0] tgt);
      insn_ready    = 1'b1;
      branch_taken  = br;
      branch_target = tgt;
      @(posedge clk);
      #1;
      insn_ready   = 1'b0;
      branch_taken = 1'b0;
   endtask

   // Monitor: compares each accepted instruction against the scoreboard head.
   initial begin
      logic [15:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (rst && insn_valid && insn_ready) begin
            if (expQ.size() == 0) begin
               nCompared++;
               nMismatched++;
               $display("[TB] FAIL scoreboard: unexpected insn %h at %h, expected none", insn, insn_pc);
            end else begin
               e = expQ.pop_front();
               checkOutput("accepted insn/insn_pc", {insn, insn_pc}, e);
            end
         end
      end
   end

   initial begin
      int t0;
      for (int i = 0; i < 256; i++) mem[i] = {1'b0, i[6:0]};
      mem[0] = 8'h12;
      mem[1] = 8'h34;
      mem[2] = 8'h56;
      mem[3] = 8'hF0;

      // Reset values visible immediately on assertion
      #1 rst = 1'b0;
      #1;
      checkOutput("reset pc", {8'h00, pc}, 16'h0000);
      checkOutput("reset insn/insn_pc", {insn, insn_pc}, 16'h0000);
      checkOutput("reset valid/halted", {15'h0, insn_valid | halted}, 16'h0000);
      #10 rst = 1'b1;

      // Plain fetch, then hold with insn_ready low and an ignored branch pulse
      pushExp(8'h12, 8'h00);
      waitValid("fetch 0");
      applyStimulus(1'b0, 8'h00);
      pushExp(8'h34, 8'h01);
      waitValid("fetch 1");
      for (int i = 0; i < 5; i++) begin
         checkOutput("hold insn/insn_pc", {insn, insn_pc}, 16'h3401);
         checkOutput("hold pc/valid", {pc, 7'h0, insn_valid}, 16'h0201);
         branch_taken  = (i == 2);
         branch_target = 8'h77;
         @(negedge clk);
      end
      branch_taken = 1'b0;
      applyStimulus(1'b0, 8'h00);
      checkOutput("pc after accept", {8'h00, pc}, 16'h0002);
      checkOutput("valid after accept", {15'h0, insn_valid}, 16'h0000);

      pushExp(8'h56, 8'h02);
      waitValid("fetch 2");
      applyStimulus(1'b1, 8'h05);
      checkOutput("branch pc 05", {8'h00, pc}, 16'h0005);

      pushExp(8'h05, 8'h05);
      waitValid("fetch 05");
      applyStimulus(1'b1, 8'hA0);
      checkOutput("branch pc A0", {8'h00, pc}, 16'h00A0);

      pushExp(8'h20, 8'hA0);
      waitValid("fetch A0");
      applyStimulus(1'b1, 8'hFF);
      checkOutput("branch pc FF", {8'h00, pc}, 16'h00FF);

      pushExp(8'h7F, 8'hFF);
      waitValid("fetch FF");
      checkOutput("pc wrap while valid", {8'h00, pc}, 16'h0000);
      applyStimulus(1'b0, 8'h00);
      checkOutput("pc wrap after accept", {8'h00, pc}, 16'h0000);

      // Stall in ISSUE for four cycles
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("stall pc/valid", {pc, 7'h0, insn_valid}, 16'h0000);
      end
      stall = 1'b0;

      // Reset pulsed mid-VALID
      pushExp(8'h12, 8'h00);
      waitValid("fetch after stall");
      checkOutput("valid before reset", {15'h0, insn_valid}, 16'h0001);
      #2 rst = 1'b0;
      #1;
      checkOutput("mid-valid reset", {pc, 7'h0, insn_valid}, 16'h0000);
      expQ.delete();
      #4 rst = 1'b1;

      // Back-to-back fetch with insn_ready held high: one accept every 3 cycles
      insn_ready = 1'b1;
      t0 = 0;
      for (int i = 0; i < 3; i++) begin
         pushExp(mem[i], i[7:0]);
         waitValid("throughput fetch");
         if (i > 0) checkOutput("cycles per insn", 16'(cycleCount - t0), 16'd3);
         t0 = cycleCount;
         @(posedge clk);
      end
      pushExp(8'hF0, 8'h03);
      waitValid("fetch halt opcode");
      @(posedge clk);
      #1;
      insn_ready = 1'b0;

`ifdef FETCH_HALT_EN
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("halted state", {pc, 6'h0, halted, insn_valid}, 16'h0402);
      end
`else
      pushExp(8'h04, 8'h04);
      insn_ready = 1'b1;
      waitValid("fetch after F0");
      checkOutput("not halted", {15'h0, halted}, 16'h0000);
      @(posedge clk);
      #1;
      insn_ready = 1'b0;
`endif

      repeat (2) @(negedge clk);
      checkOutput("scoreboard drained", 16'(expQ.size()), 16'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

   initial begin
      #50000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog");
   end

endmodule
